// File: rtl/ex_mdu_if.sv
// Request/response bundle for the multiply/divide unit; slave is the unit, master the issuing pipeline.
// Parameters must match the ex_mdu instance attached to it.
interface ex_mdu_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic             req_valid_i;
   logic             req_ready_o;
   logic [2:0]       fun3_i;
   logic [XLEN-1:0]  op1_i;
   logic [XLEN-1:0]  op2_i;
   logic [TAG_W-1:0] tag_i;
   logic             flush_i;
   logic             resp_valid_o;
   logic             resp_ready_i;
   logic [XLEN-1:0]  result_o;
   logic [TAG_W-1:0] tag_o;

   modport slave (
      input  req_valid_i, fun3_i, op1_i, op2_i, tag_i, flush_i, resp_ready_i,
      output req_ready_o, resp_valid_o, result_o, tag_o
   );

   modport master (
      output req_valid_i, fun3_i, op1_i, op2_i, tag_i, flush_i, resp_ready_i,
      input  req_ready_o, resp_valid_o, result_o, tag_o
   );
endinterface

// File: rtl/ex_mdu.sv
// Iterative RV M-extension unit: shift-add multiply / restoring divide, XLEN+1 cycle latency (1 for div-by-zero/overflow).
// One op in flight; result held in DONE until resp_ready_i, req_ready_o only in IDLE; flush_i kills from any state.
module ex_mdu #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic     clk,
   input  logic     rst_n,
   ex_mdu_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [5:0]      LAST_IT = 6'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [2:0]        fun3_q, fun3_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic              qneg_q, qneg_d;
   logic              rneg_q, rneg_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [2*XLEN-1:0] acc_q, acc_d;

   logic              accept, s1, s2, n1, n2, div0, ovf, last, div_ge;
   logic [XLEN-1:0]   op1_mag, op2_mag, div_rem, quo, rem, mul_hi, mul_lo, prod_hi;
   logic [XLEN:0]     mul_sum, div_top;
   logic [2*XLEN-1:0] mul_nx, div_nx;

   assign accept  = bus.req_valid_i && (state_q == IDLE) && !bus.flush_i;
   assign s1      = bus.fun3_i inside {3'd1, 3'd2, 3'd4, 3'd6};
   assign s2      = bus.fun3_i inside {3'd1, 3'd4, 3'd6};
   assign n1      = s1 && bus.op1_i[XLEN-1];
   assign n2      = s2 && bus.op2_i[XLEN-1];
   assign op1_mag = n1 ? -bus.op1_i : bus.op1_i;
   assign op2_mag = n2 ? -bus.op2_i : bus.op2_i;
   assign div0    = bus.fun3_i[2] && (bus.op2_i == '0);
   assign ovf     = ((bus.fun3_i == 3'd4) || (bus.fun3_i == 3'd6)) &&
                    (bus.op1_i == MIN_NEG) && (bus.op2_i == '1);
   assign last    = (cnt_q == LAST_IT);

   // acc holds {product_hi, multiplier} for MUL* and {remainder, dividend/quotient} for DIV*
   assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
   assign mul_nx  = {mul_sum, acc_q[XLEN-1:1]};
   assign div_top = acc_q[2*XLEN-1:XLEN-1];
   assign div_ge  = div_top >= {1'b0, b_q};
   assign div_rem = div_top[XLEN-1:0] - b_q;
   assign div_nx  = {(div_ge ? div_rem : div_top[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
   assign quo     = div_nx[XLEN-1:0];
   assign rem     = div_nx[2*XLEN-1:XLEN];
   assign mul_hi  = mul_nx[2*XLEN-1:XLEN];
   assign mul_lo  = mul_nx[XLEN-1:0];
   // High half of the two's-complement negated product: ~hi plus the carry out of ~lo+1
   assign prod_hi = qneg_q ? (~mul_hi + XLEN'(mul_lo == '0)) : mul_hi;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = (div0 || ovf) ? DONE : CALC;
         CALC:    if (last) state_d = DONE;
         DONE:    if (bus.resp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.flush_i) state_d = IDLE;
   end

   always_comb begin
      bus.req_ready_o  = (state_q == IDLE);
      bus.resp_valid_o = (state_q == DONE);
      bus.result_o     = result_q;
      bus.tag_o        = tag_q;
   end

   always_comb begin
      cnt_d    = cnt_q;
      fun3_d   = fun3_q;
      tag_d    = tag_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      b_d      = b_q;
      acc_d    = acc_q;
      result_d = result_q;
      if (accept) begin
         cnt_d  = '0;
         fun3_d = bus.fun3_i;
         tag_d  = bus.tag_i;
         qneg_d = n1 ^ n2;
         rneg_d = n1;
         b_d    = op2_mag;
         acc_d  = {{XLEN{1'b0}}, op1_mag};
         if (div0)     result_d = bus.fun3_i[1] ? bus.op1_i : '1;
         else if (ovf) result_d = bus.fun3_i[1] ? '0 : bus.op1_i;
      end else if (state_q == CALC) begin
         cnt_d = cnt_q + 6'd1;
         acc_d = fun3_q[2] ? div_nx : mul_nx;
         if (last) begin
            if (fun3_q[2] && fun3_q[1])  result_d = rneg_q ? -rem : rem;
            else if (fun3_q[2])          result_d = qneg_q ? -quo : quo;
            else if (fun3_q == 3'd0)     result_d = mul_lo;
            else                         result_d = prod_hi;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         fun3_q   <= '0;
         tag_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         fun3_q   <= fun3_d;
         tag_q    <= tag_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end
endmodule

// File: tb/tb_ex_mdu.sv
// Directed + random checks of ex_mdu (XLEN=32) against a behavioural reference and a response scoreboard.
module tb_ex_mdu;
   localparam int XLEN  = 32;
   localparam int TAG_W = 5;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  tag;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t exp_q[$];

   ex_mdu_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus();
   ex_mdu #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      logic        ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
         3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && b == 0) return 1;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 1;
   endfunction

   // Called at posedge+#1 with the DUT idle; returns just after the accepting edge.
   task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
      exp_t e;
      e.res = ref_mdu(f, a, b);
      e.tag = t;
      e.lat = exp_lat(f, a, b);
      exp_q.push_back(e);
      chk("req_ready_idle", 64'(bus.req_ready_o), 64'd1);
      bus.req_valid_i = 1'b1;
      bus.fun3_i = f;
      bus.op1_i = a;
      bus.op2_i = b;
      bus.tag_i = t;
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
   endtask

   task automatic collect(input int hold);
      exp_t e;
      int   lat;
      logic busy_ok;
      lat = 1;
      busy_ok = 1'b1;
      while (!bus.resp_valid_o && lat < 200) begin
         if (bus.req_ready_o !== 1'b0) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      chk("ready_low_busy", 64'(busy_ok), 64'd1);
      chk("resp_valid", 64'(bus.resp_valid_o), 64'd1);
      e = exp_q.pop_front();
      chk("latency", 64'(lat), 64'(e.lat));
      chk("result", 64'(bus.result_o), 64'(e.res));
      chk("tag", 64'(bus.tag_o), 64'(e.tag));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", 64'(bus.resp_valid_o), 64'd1);
         chk("hold_result", 64'(bus.result_o), 64'(e.res));
         chk("hold_tag", 64'(bus.tag_o), 64'(e.tag));
         chk("hold_req_ready", 64'(bus.req_ready_o), 64'd0);
      end
      bus.resp_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready_i = 1'b0;
      chk("consumed_valid", 64'(bus.resp_valid_o), 64'd0);
      chk("consumed_ready", 64'(bus.req_ready_o), 64'd1);
   endtask

   initial begin
      logic seen;
      exp_t e;
      bus.req_valid_i = 1'b0;
      bus.fun3_i = '0;
      bus.op1_i = '0;
      bus.op2_i = '0;
      bus.tag_i = '0;
      bus.flush_i = 1'b0;
      bus.resp_ready_i = 1'b0;

      #12;
      chk("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
      chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
      chk("rst_result", 64'(bus.result_o), 64'd0);
      chk("rst_tag", 64'(bus.tag_o), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      send(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3);                    collect(0);
      send(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4);             collect(0);
      send(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd5);             collect(0);
      send(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd6);                     collect(0);
      send(3'd4, 32'd7, 32'd0, 5'd7);                             collect(0);
      send(3'd6, 32'd7, 32'd0, 5'd8);                             collect(0);
      send(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);             collect(0);
      send(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);            collect(0);
      send(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd11);                    collect(5);
      send(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd12);                    collect(0);
      send(3'd5, 32'hFFFF_FFFF, 32'd1, 5'd13);                    collect(0);
      send(3'd7, 32'd100, 32'd7, 5'd14);                          collect(0);

      for (int i = 0; i < 10; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = (i % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom;
         if (i % 4 == 1) b = -b;
         send(3'($urandom_range(0, 7)), a, b, 5'(i + 16));
         collect(i % 2);
      end

      // Flush at CALC cycle 10 kills the op; a new request goes in on the following cycle.
      bus.req_valid_i = 1'b1;
      bus.fun3_i = 3'd0;
      bus.op1_i = 32'd5;
      bus.op2_i = 32'd9;
      bus.tag_i = 5'd30;
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      bus.flush_i = 1'b1;
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
      chk("flush_resp_valid", 64'(bus.resp_valid_o), 64'd0);
      chk("flush_req_ready", 64'(bus.req_ready_o), 64'd1);
      send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);            collect(0);

      // A flush alongside a valid request in IDLE blocks acceptance.
      bus.req_valid_i = 1'b1;
      bus.flush_i = 1'b1;
      bus.op2_i = 32'd0;
      bus.fun3_i = 3'd4;
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      bus.flush_i = 1'b0;
      chk("flush_idle_ready", 64'(bus.req_ready_o), 64'd1);
      chk("flush_idle_valid", 64'(bus.resp_valid_o), 64'd0);

      // Flush wins over resp_ready in DONE.
      send(3'd5, 32'd9, 32'd0, 5'd2);
      e = exp_q.pop_front();
      chk("done_flush_valid_before", 64'(bus.resp_valid_o), 64'd1);
      chk("done_flush_result", 64'(bus.result_o), 64'(e.res));
      bus.flush_i = 1'b1;
      bus.resp_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
      bus.resp_ready_i = 1'b0;
      chk("done_flush_valid_after", 64'(bus.resp_valid_o), 64'd0);
      chk("done_flush_ready_after", 64'(bus.req_ready_o), 64'd1);

      // Reset in the middle of CALC abandons the op.
      bus.req_valid_i = 1'b1;
      bus.fun3_i = 3'd1;
      bus.op1_i = 32'h1234_5678;
      bus.op2_i = 32'h9ABC_DEF0;
      bus.tag_i = 5'd21;
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
      chk("midrst_req_ready", 64'(bus.req_ready_o), 64'd1);
      chk("midrst_result", 64'(bus.result_o), 64'd0);
      chk("midrst_tag", 64'(bus.tag_o), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.resp_valid_o !== 1'b0) seen = 1'b1;
      end
      chk("postrst_no_resp", 64'(seen), 64'd0);
      chk("postrst_ready", 64'(bus.req_ready_o), 64'd1);
      send(3'd6, 32'hFFFF_FF9C, 32'd7, 5'd1);                     collect(0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
